fsm_seq_sched: RTL and testbench
================================

Name: fsm_seq_sched

Overview:
- Shares one bit-serial sequence-detector FSM engine among N requesters, each presenting a W-bit word.
- Round-robin arbitration selects one requester. The block clears the engine, shifts the granted word in one bit per clock and counts the engine's x event pulses.
- Returns the counts, the final y level and the requester id on a valid/ready response port.
- Sits between requester logic and the engine. The engine's clock is clk.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, bits per word.
- CW, 4, width of each event counter.
- IDW, 2, width of rsp_id; must be at least clog2(N).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N  per-requester word available
- req_ready  out  N  one-hot grant/accept, combinational
- req_data  in  N*W  words; requester k uses bits [k*W +: W]
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_id  out  IDW  requester that produced the result
- rsp_cnt_a  out  CW  number of eng_x==1 pulses
- rsp_cnt_b  out  CW  number of eng_x==2 pulses
- rsp_y  out  1  engine y sampled in DRAIN
- eng_rst  out  1  engine synchronous reset
- eng_i  out  1  engine serial input
- eng_x  in  8  engine event output (registered in engine)
- eng_y  in  1  engine level output (registered in engine)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: state IDLE, rr pointer 0, rsp_valid 0, rsp_id 0, counters 0, rsp_y 0, eng_i 0.
- eng_rst = rst | (state==CLR).
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - The grant goes to the first k with req_valid[k]=1, searching from the rr pointer upward with wrap-around.
  - req_ready[k] is high only for that k, only in IDLE, and with no requests pending it is all zero.
  - On handshake (cycle T): latch the word, latch id=k, set rr pointer to (k+1) mod N, clear the counters, go to CLR.
- CLR (T+1): eng_rst=1 for exactly one cycle; eng_i=0.
- SHIFT (T+2 .. T+W+1):
  - eng_i = latched bit j, LSB first, j=0..W-1; a bit counter selects the bit.
  - eng_x observed in cycle c reflects the bit driven in cycle c-1.
  - Sample eng_x in every SHIFT cycle except the first.
- DRAIN (T+W+2):
  - eng_i=0; sample eng_x one last time, which covers bit W-1.
  - Latch rsp_y = eng_y.
- Counting: eng_x==1 increments cnt_a; eng_x==2 increments cnt_b; any other value is ignored. Both counters saturate at 2^CW-1, with no wrap.
- DONE (from T+W+3):
  - rsp_valid=1; rsp_id and the counts are held stable until the rsp_valid&rsp_ready cycle, then go to IDLE.
  - No new grant is issued in the cycle the response is taken.
- rsp_ready may already be high on entry to DONE. The handshake then completes in the first DONE cycle.
- Requesters may drop req_valid while not granted. Data is sampled only on the handshake.
- Reset mid-operation: immediate return to IDLE, rsp_valid drops, the result is lost and eng_rst is high during rst.

Optional Feature:
- Macro: FSM_SEQ_SCHED_MSB_FIRST_EN.
- Defined: SHIFT drives bits W-1 down to 0 (MSB first).
- Undefined: LSB first as above.
- All other timing is identical.

Test Plan:
- Single requester, req 0 data 0xFF -> rsp_valid at T+11, id 0, cnt_a 3, cnt_b 0, rsp_y 1.
- Req 1 data 0xAB (bits 1,1,0,1,0,1,0,1 LSB first) -> cnt_a 2, cnt_b 2, rsp_y 1; the last x=2 pulse is counted only in DRAIN.
- Req 2 data 0x00 -> cnt_a 0, cnt_b 0, rsp_y 0; eng_rst high exactly in cycle T+1.
- All 4 valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0; req_ready is never multi-hot.
- rsp_ready held 0 for 5 cycles in DONE -> outputs stable and no req_ready asserted; release -> IDLE the next cycle.
- rst asserted during SHIFT bit 4 -> next cycle IDLE, rsp_valid 0, rr pointer 0, then a clean transaction succeeds.

Source files
------------

// File: rtl/fsm_seq_sched.sv
// fsm_seq_sched: shares one bit-serial sequence-detector engine among N requesters.
//
// A round-robin arbiter picks one requester. The block resets the engine, shifts the
// granted word in one bit per clock and counts the engine's x==1 and x==2 pulses.
// It then returns the counts, the final y level and the requester id on a
// valid/ready response port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid_i     per-requester word available
//   req_ready_o     one-hot grant (combinational, IDLE only)
//   req_data_i      N packed W-bit words, requester k at [k*W +: W]
//   rsp_valid_o     result available (DONE)
//   rsp_ready_i     result consumed
//   rsp_id_o        requester that produced the result
//   rsp_cnt_a_o     saturating count of eng_x==1 pulses
//   rsp_cnt_b_o     saturating count of eng_x==2 pulses
//   rsp_y_o         engine y sampled in DRAIN
//   eng_rst_o       engine synchronous reset
//   eng_i_o         engine serial input
//   eng_x_i         engine event output (registered in engine)
//   eng_y_i         engine level output (registered in engine)
//
// Build option: FSM_SEQ_SCHED_MSB_FIRST_EN shifts each word MSB first instead of LSB first.
module fsm_seq_sched #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned CW  = 4,
  parameter int unsigned IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid_i,
  output logic [N-1:0]   req_ready_o,
  input  logic [N*W-1:0] req_data_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [IDW-1:0] rsp_id_o,
  output logic [CW-1:0]  rsp_cnt_a_o,
  output logic [CW-1:0]  rsp_cnt_b_o,
  output logic           rsp_y_o,
  output logic           eng_rst_o,
  output logic           eng_i_o,
  input  logic [7:0]     eng_x_i,
  input  logic           eng_y_i
);

  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {StIdle, StClr, StShift, StDrain, StDone} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   word_q, word_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [CW-1:0]  cnt_a_q, cnt_a_d;
  logic [CW-1:0]  cnt_b_q, cnt_b_d;
  logic           y_q, y_d;

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic           gnt_found;
  int unsigned    gnt_k;
  logic [W-1:0]   word_sel;
  logic           sample;

  // Round-robin search: rotate the request vector so the pointer lands on bit 0, take the
  // lowest set bit, then map the offset back to a requester index.
  always_comb begin
    req_dbl   = {req_valid_i, req_valid_i} >> rr_q;
    req_rot   = req_dbl[N-1:0];
    gnt_found = 1'b0;
    gnt_k     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_found && req_rot[i]) begin
        gnt_found = 1'b1;
        gnt_k     = 32'(rr_q) + i;
        if (gnt_k >= N) gnt_k = gnt_k - N;
      end
    end
    word_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (k == gnt_k) word_sel = req_data_i[k*W +: W];
    end
  end

  // eng_x lags eng_i by one cycle: skip the first SHIFT cycle, pick up the last bit in DRAIN.
  assign sample = ((state_q == StShift) && (bit_q != '0)) || (state_q == StDrain);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    word_d  = word_q;
    bit_d   = bit_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    y_d     = y_q;

    case (state_q)
      StIdle: begin
        if (gnt_found) begin
          state_d = StClr;
          word_d  = word_sel;
          id_d    = IDW'(gnt_k);
          rr_d    = IDW'((gnt_k + 1) % N);
          cnt_a_d = '0;
          cnt_b_d = '0;
        end
      end
      StClr: begin
        bit_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (bit_q == BW'(W - 1)) state_d = StDrain;
        else                     bit_d   = bit_q + 1'b1;
      end
      StDrain: begin
        y_d     = eng_y_i;
        state_d = StDone;
      end
      StDone: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (sample) begin
      if (eng_x_i == 8'd1 && cnt_a_q != '1) cnt_a_d = cnt_a_q + 1'b1;
      if (eng_x_i == 8'd2 && cnt_b_q != '1) cnt_b_d = cnt_b_q + 1'b1;
    end
  end

  always_comb begin
    eng_i_o = 1'b0;
    if (state_q == StShift) begin
`ifdef FSM_SEQ_SCHED_MSB_FIRST_EN
      eng_i_o = word_q[BW'(W - 1) - bit_q];
`else
      eng_i_o = word_q[bit_q];
`endif
    end
  end

  assign req_ready_o = (state_q == StIdle && gnt_found) ? (N'(1) << gnt_k) : '0;
  assign eng_rst_o   = rst | (state_q == StClr);
  assign rsp_valid_o = (state_q == StDone);
  assign rsp_id_o    = id_q;
  assign rsp_cnt_a_o = cnt_a_q;
  assign rsp_cnt_b_o = cnt_b_q;
  assign rsp_y_o     = y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      id_q    <= '0;
      word_q  <= '0;
      bit_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      y_q     <= y_d;
    end
  end

endmodule

// File: tb/tb_fsm_seq_sched.sv
// Bench for fsm_seq_sched. A behavioural sequence-detector engine drives eng_x/eng_y.
// A second instance with 2-bit counters shares the stimulus to expose saturation.
// Expected responses are queued when a grant is issued and popped when rsp_valid rises.
module tb_fsm_seq_sched;
  localparam int N = 4;
  localparam int W = 8;
  localparam int CW = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid, req_ready, req_ready_s;
  logic [N*W-1:0] req_data;
  logic           rsp_valid, rsp_ready, rsp_y;
  logic [IDW-1:0] rsp_id;
  logic [CW-1:0]  cnt_a, cnt_b;
  logic           eng_rst, eng_i, eng_y;
  logic [7:0]     eng_x;
  logic           rsp_valid_s, rsp_y_s, eng_rst_s, eng_i_s;
  logic [IDW-1:0] rsp_id_s;
  logic [1:0]     cnt_a_s, cnt_b_s;

  fsm_seq_sched #(.N(N), .W(W), .CW(CW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_cnt_a_o(cnt_a), .rsp_cnt_b_o(cnt_b), .rsp_y_o(rsp_y),
    .eng_rst_o(eng_rst), .eng_i_o(eng_i), .eng_x_i(eng_x), .eng_y_i(eng_y)
  );

  fsm_seq_sched #(.N(N), .W(W), .CW(2), .IDW(IDW)) dut_s (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_s),
    .req_data_i(req_data), .rsp_valid_o(rsp_valid_s), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id_s), .rsp_cnt_a_o(cnt_a_s), .rsp_cnt_b_o(cnt_b_s), .rsp_y_o(rsp_y_s),
    .eng_rst_o(eng_rst_s), .eng_i_o(eng_i_s), .eng_x_i(eng_x), .eng_y_i(eng_y)
  );

  // Engine: states 0 idle, 1 "1", 2 after "11", 3 after "110", 4 "10".
  // x=1 on "11" and on "1101"; x=2 on "101"; x=3 (to be ignored) on "111".
  function automatic logic [10:0] eng_step(input logic [2:0] st, input logic b);
    logic [2:0] ns;
    logic [7:0] x;
    ns = 3'd0;
    x  = 8'd0;
    case (st)
      3'd0: ns = b ? 3'd1 : 3'd0;
      3'd1: if (b) begin ns = 3'd2; x = 8'd1; end else ns = 3'd4;
      3'd2: if (b) begin ns = 3'd0; x = 8'd3; end else ns = 3'd3;
      3'd3: if (b) begin ns = 3'd1; x = 8'd1; end else ns = 3'd0;
      3'd4: if (b) begin ns = 3'd1; x = 8'd2; end else ns = 3'd0;
      default: ns = 3'd0;
    endcase
    return {ns, x};
  endfunction

  logic [2:0] eng_st, eng_ns;
  logic [7:0] eng_xn;
  assign {eng_ns, eng_xn} = eng_step(eng_st, eng_i);

  always @(posedge clk) begin
    if (eng_rst) begin
      eng_st <= 3'd0;
      eng_x  <= 8'd0;
      eng_y  <= 1'b0;
    end else begin
      eng_st <= eng_ns;
      eng_x  <= eng_xn;
      eng_y  <= eng_i;
    end
  end

  typedef struct {
    logic [IDW-1:0] id;
    int             a;
    int             b;
    logic           y;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic exp_t model(input int id, input logic [W-1:0] w);
    exp_t e;
    logic [2:0] st;
    logic [10:0] r;
    logic b;
    st = 3'd0;
    e.id = IDW'(id);
    e.a = 0;
    e.b = 0;
    e.y = 1'b0;
    for (int j = 0; j < W; j++) begin
`ifdef FSM_SEQ_SCHED_MSB_FIRST_EN
      b = w[W-1-j];
`else
      b = w[j];
`endif
      r = eng_step(st, b);
      st = r[10:8];
      if (r[7:0] == 8'd1) e.a++;
      else if (r[7:0] == 8'd2) e.b++;
      e.y = b;
    end
    return e;
  endfunction

  // Expected response fields of both instances, packed for a single comparison.
  function automatic logic [17:0] pack_exp(input exp_t e);
    return {1'b1, e.id, CW'(sat(e.a, 15)), CW'(sat(e.b, 15)), e.y,
            2'(sat(e.a, 3)), 2'(sat(e.b, 3)), e.id};
  endfunction

  function automatic logic [17:0] obs_rsp();
    return {rsp_valid_s, rsp_id, cnt_a, cnt_b, rsp_y, cnt_a_s, cnt_b_s, rsp_id_s};
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Waits (from just after a handshake edge) for rsp_valid; cyc = -1 on timeout.
  task automatic wait_rsp(output int cyc);
    cyc = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (eng_rst !== 1'b1 || eng_rst_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_eng_rst: got %b/%b want 1/1", eng_rst, eng_rst_s);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    obs = 32'({rsp_valid, rsp_id, cnt_a, cnt_b, rsp_y, eng_i, eng_rst, req_ready,
               rsp_valid_s, eng_i_s, eng_rst_s, req_ready_s});
    checks++;
    if (obs !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
  endtask

  task automatic test_single(input int id, input logic [W-1:0] data, input int ea,
                             input int eb, input logic ey, input string name);
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    req_data[id*W +: W] = data;
    req_valid = onehot(id);
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== onehot(id) || eng_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s_grant: got ready %b eng_rst %b want %b 0", name, req_ready, eng_rst,
               onehot(id));
    end
    e.id = IDW'(id); e.a = ea; e.b = eb; e.y = ey;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = '0;
    n = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (eng_rst !== (c == 1)) begin
        errors++;
        $display("FAIL %s_eng_rst T+%0d: got %b want %b", name, c, eng_rst, (c == 1));
      end
      if (rsp_valid) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != 11) begin
      errors++;
      $display("FAIL %s_latency: got T+%0d want T+11", name, n);
    end
    checks++;
    if (sbq.size() == 0 || n < 0) begin
      errors++;
      $display("FAIL %s_rsp: no response (valid %b) want one", name, rsp_valid);
      if (sbq.size() != 0) void'(sbq.pop_front());
    end else begin
      e = sbq.pop_front();
      if (obs_rsp() !== pack_exp(e)) begin
        errors++;
        $display("FAIL %s_rsp: got %h want %h", name, obs_rsp(), pack_exp(e));
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int n;
    logic got;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) req_data[k*W +: W] = W'($urandom);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        got = (req_ready != '0);
      end
      checks++;
      if (!got || req_ready !== onehot(t % N)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b want %b", t, req_ready, onehot(t % N));
      end
      sbq.push_back(model(t % N, req_data[(t % N)*W +: W]));
      n = -1;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        checks++;
        if ($countones(req_ready) > 1) begin
          errors++;
          $display("FAIL rr_onehot: got %b want at most one bit", req_ready);
        end
        if (rsp_valid) begin
          n = c;
          break;
        end
      end
      checks++;
      e = sbq.pop_front();
      if (n < 0 || obs_rsp() !== pack_exp(e)) begin
        errors++;
        $display("FAIL rr_rsp%0d: got %h (T+%0d) want %h", t, obs_rsp(), n, pack_exp(e));
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    req_data[1*W +: W] = W'($urandom);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant: got %b want 0010", req_ready);
    end
    sbq.push_back(model(1, req_data[1*W +: W]));
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(n);
    e = sbq.pop_front();
    checks++;
    if (n != 11 || obs_rsp() !== pack_exp(e)) begin
      errors++;
      $display("FAIL bp_rsp: got %h at T+%0d want %h at T+11", obs_rsp(), n, pack_exp(e));
    end
    @(posedge clk);
    #1 req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== '0 || obs_rsp() !== pack_exp(e)) begin
        errors++;
        $display("FAIL bp_hold%0d: got v %b ready %b rsp %h want 1 0 %h", i, rsp_valid,
                 req_ready, obs_rsp(), pack_exp(e));
      end
      if (i < 4) @(posedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== '0) begin
      errors++;
      $display("FAIL bp_take: got v %b ready %b want 1 0000", rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_idle: got v %b ready %b want 0 0100", rsp_valid, req_ready);
    end
    sbq.push_back(model(2, req_data[2*W +: W]));
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(n);
    e = sbq.pop_front();
    checks++;
    if (n != 11 || obs_rsp() !== pack_exp(e)) begin
      errors++;
      $display("FAIL b2b_rsp: got %h at T+%0d want %h at T+11", obs_rsp(), n, pack_exp(e));
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n;
    @(posedge clk);
    #1;
    req_data[3*W +: W] = 8'hFF;
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rmid_grant: got %b want 1000", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_rst !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_during: got eng_rst %b v %b want 1 0", eng_rst, rsp_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rmid_idle: got v %b ready %b want 0 0001", rsp_valid, req_ready);
    end
    sbq.push_back(model(0, req_data[0 +: W]));
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp(n);
    e = sbq.pop_front();
    checks++;
    if (n != 11 || obs_rsp() !== pack_exp(e)) begin
      errors++;
      $display("FAIL rmid_rsp: got %h at T+%0d want %h at T+11", obs_rsp(), n, pack_exp(e));
    end
  endtask

  task automatic test_random();
    exp_t e;
    int n, id, d;
    @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) begin
      id = $urandom_range(0, N - 1);
      req_data[id*W +: W] = W'($urandom);
      req_valid = onehot(id);
      rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== onehot(id)) begin
        errors++;
        $display("FAIL rnd_grant%0d: got %b want %b", r, req_ready, onehot(id));
      end
      sbq.push_back(model(id, req_data[id*W +: W]));
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(n);
      e = sbq.pop_front();
      checks++;
      if (n != 11 || obs_rsp() !== pack_exp(e)) begin
        errors++;
        $display("FAIL rnd_rsp%0d: got %h at T+%0d want %h", r, obs_rsp(), n, pack_exp(e));
      end
      d = $urandom_range(0, 3);
      repeat (d) @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single(0, 8'hFF, 3, 0, 1'b1, "ff");
    test_single(1, 8'hAB, 2, 2, 1'b1, "ab");
    test_single(2, 8'h00, 0, 0, 1'b0, "zero");
    test_single(3, 8'h5B, 4, 0, 1'b0, "sat");
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    test_random();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "time limit");
  end

endmodule
